// File: rtl/cnn_layer_feeder.sv
// Streaming initiator for one CNN convolution layer: host-loaded image/filter buffers,
// Start/filter/image/ReadEn sequencing and result capture. Optional checksum: FEEDER_CKSUM_EN.
//
// state | meaning
// IDLE  | waiting for go, host may load buffers
// START | Start pulse to the layer
// FILT  | streaming filter taps
// IMG   | streaming image pixels
// WAIT  | layer compute time before reading
// READ  | ReadEn high, one result requested per cycle
// DRAIN | last results still in flight
// DONE  | done pulse, back to IDLE
module cnn_layer_feeder #(
  parameter int IMG_W      = 4,
  parameter int FILT_W     = 4,
  parameter int RES_W      = 10,
  parameter int IMG_DEPTH  = 16,
  parameter int FILT_DEPTH = 9,
  parameter int OUT_CNT    = 4,
  parameter int WAIT_CYC   = 2,
  parameter int READ_LAT   = 1,
  localparam int LD_DEPTH  = (IMG_DEPTH > FILT_DEPTH) ? IMG_DEPTH : FILT_DEPTH,
  localparam int AW        = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1,
  localparam int DW        = (IMG_W > FILT_W) ? IMG_W : FILT_W,
  localparam int RA_W      = (OUT_CNT > 1) ? $clog2(OUT_CNT) : 1,
  localparam int CW        = RES_W + 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_we,
  input  logic              ld_sel,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DW-1:0]     ld_data,
  input  logic              go,
  output logic              busy,
  output logic              done,
  input  logic [RA_W-1:0]   rd_addr,
  output logic [RES_W-1:0]  rd_data,
  output logic [CW-1:0]     cksum,
  output logic              Start,
  output logic [IMG_W-1:0]  Image,
  output logic [FILT_W-1:0] Filter,
  output logic              ReadEn,
  input  logic [RES_W-1:0]  Result
);

  localparam int T_A   = (LD_DEPTH > WAIT_CYC) ? LD_DEPTH : WAIT_CYC;
  localparam int T_B   = (OUT_CNT > READ_LAT) ? OUT_CNT : READ_LAT;
  localparam int T_MAX = (T_A > T_B) ? T_A : T_B;
  localparam int TW    = $clog2(T_MAX + 1);

  localparam logic [AW:0]   IMG_LIM  = (AW + 1)'(IMG_DEPTH);
  localparam logic [AW:0]   FILT_LIM = (AW + 1)'(FILT_DEPTH);
  localparam logic [RA_W:0] OUT_LIM  = (RA_W + 1)'(OUT_CNT);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_FILT, S_IMG, S_WAIT, S_READ, S_DRAIN, S_DONE
  } state_t;

  state_t              state;
  logic [TW-1:0]       tmr;
  logic [AW-1:0]       idx;
  logic [RA_W-1:0]     wptr;
  logic [READ_LAT-1:0] rd_pipe;
  logic                cap;

  logic [IMG_W-1:0]  img_buf  [IMG_DEPTH];
  logic [FILT_W-1:0] filt_buf [FILT_DEPTH];
  logic [RES_W-1:0]  res_buf  [OUT_CNT];

  assign cap = rd_pipe[READ_LAT-1];

  // Buffers are deliberately not reset so host data survives a reset.
  always_ff @(posedge clk) begin
    if (ld_we && !busy) begin
      if (!ld_sel && ({1'b0, ld_addr} < IMG_LIM))
        img_buf[ld_addr] <= ld_data[IMG_W-1:0];
      if (ld_sel && ({1'b0, ld_addr} < FILT_LIM))
        filt_buf[ld_addr] <= ld_data[FILT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (cap)
      res_buf[wptr] <= Result;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rd_data <= '0;
    else if ({1'b0, rd_addr} < OUT_LIM)
      rd_data <= res_buf[rd_addr];
    else
      rd_data <= '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      Start   <= 1'b0;
      ReadEn  <= 1'b0;
      Image   <= '0;
      Filter  <= '0;
      tmr     <= '0;
      idx     <= '0;
      wptr    <= '0;
      rd_pipe <= '0;
    end else begin
      rd_pipe <= (rd_pipe << 1) | READ_LAT'(ReadEn);
      if (cap)
        wptr <= wptr + 1'b1;
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (go) begin
            state <= S_START;
            busy  <= 1'b1;
            Start <= 1'b1;
          end
        end
        S_START: begin
          Start  <= 1'b0;
          wptr   <= '0;
          Filter <= filt_buf[0];
          idx    <= AW'(1);
          tmr    <= TW'(FILT_DEPTH - 1);
          state  <= S_FILT;
        end
        S_FILT: begin
          if (tmr == '0) begin
            Filter <= '0;
            Image  <= img_buf[0];
            idx    <= AW'(1);
            tmr    <= TW'(IMG_DEPTH - 1);
            state  <= S_IMG;
          end else begin
            Filter <= filt_buf[idx];
            idx    <= idx + 1'b1;
            tmr    <= tmr - 1'b1;
          end
        end
        S_IMG: begin
          if (tmr == '0) begin
            Image <= '0;
            if (WAIT_CYC == 0) begin
              ReadEn <= 1'b1;
              tmr    <= TW'(OUT_CNT - 1);
              state  <= S_READ;
            end else begin
              tmr   <= TW'(WAIT_CYC - 1);
              state <= S_WAIT;
            end
          end else begin
            Image <= img_buf[idx];
            idx   <= idx + 1'b1;
            tmr   <= tmr - 1'b1;
          end
        end
        S_WAIT: begin
          if (tmr == '0) begin
            ReadEn <= 1'b1;
            tmr    <= TW'(OUT_CNT - 1);
            state  <= S_READ;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        S_READ: begin
          if (tmr == '0) begin
            ReadEn <= 1'b0;
            tmr    <= TW'(READ_LAT - 1);
            state  <= S_DRAIN;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        S_DRAIN: begin
          if (tmr == '0) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FEEDER_CKSUM_EN
  // Wrapping sum of sign-extended captured results; holds until the next frame starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cksum <= '0;
    else if (state == S_START)
      cksum <= '0;
    else if (cap)
      cksum <= cksum + {{4{Result[RES_W-1]}}, Result};
  end
`else
  assign cksum = '0;
`endif

endmodule

// File: tb/tb_cnn_layer_feeder.sv
// Directed bench for cnn_layer_feeder: scoreboard queues for bus streams and results,
// with a behavioural layer model answering ReadEn after one cycle.
module tb_cnn_layer_feeder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_we;
  logic        ld_sel;
  logic [3:0]  ld_addr;
  logic [3:0]  ld_data;
  logic        go;
  logic        busy;
  logic        done;
  logic [1:0]  rd_addr;
  logic [9:0]  rd_data;
  logic [13:0] cksum;
  logic        Start;
  logic [3:0]  Image;
  logic [3:0]  Filter;
  logic        ReadEn;
  logic [9:0]  Result;

  int total = 0;
  int bad   = 0;

  logic [3:0] exp_filt [$];
  logic [3:0] exp_img  [$];
  logic [9:0] exp_res  [$];
  logic [9:0] layer_q  [$];
  logic [3:0] filt_vals [9];
  logic [3:0] img_vals  [16];

  cnn_layer_feeder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ld_we   (ld_we),
    .ld_sel  (ld_sel),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .go      (go),
    .busy    (busy),
    .done    (done),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .cksum   (cksum),
    .Start   (Start),
    .Image   (Image),
    .Filter  (Filter),
    .ReadEn  (ReadEn),
    .Result  (Result)
  );

  always #5 clk = ~clk;

  // Layer model: a result appears the cycle after ReadEn is seen high.
  always @(posedge clk) begin
    if (ReadEn && layer_q.size() > 0)
      Result <= layer_q.pop_front();
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic ld(input logic sel, input int addr, input logic [3:0] data);
    ld_we   = 1'b1;
    ld_sel  = sel;
    ld_addr = 4'(addr);
    ld_data = data;
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  task automatic push_stream();
    for (int k = 0; k < 9; k++) exp_filt.push_back(filt_vals[k]);
    for (int p = 0; p < 16; p++) exp_img.push_back(img_vals[p]);
  endtask

  task automatic set_layer(input int v0, input int v1, input int v2, input int v3);
    layer_q.push_back(10'(v0)); exp_res.push_back(10'(v0));
    layer_q.push_back(10'(v1)); exp_res.push_back(10'(v1));
    layer_q.push_back(10'(v2)); exp_res.push_back(10'(v2));
    layer_q.push_back(10'(v3)); exp_res.push_back(10'(v3));
  endtask

  task automatic check_results();
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      @(negedge clk);
      chk($sformatf("rd_data[%0d]", i), 32'(rd_data), 32'(exp_res.pop_front()));
    end
  endtask

  // Issues go and checks every bus signal cycle by cycle against the expected timeline.
  task automatic run_frame(input int abort_at, input bit disturb);
    logic [3:0] ef, ei;
    go = 1'b1;
    @(negedge clk);
    go    = 1'b0;
    ld_we = 1'b0;
    for (int c = 1; c <= 36; c++) begin
      if (c > 1) @(negedge clk);
      ef = (c >= 2 && c <= 10) ? exp_filt.pop_front() : 4'h0;
      ei = (c >= 11 && c <= 26) ? exp_img.pop_front() : 4'h0;
      chk($sformatf("start@%0d", c),  32'(Start),  32'(c == 1));
      chk($sformatf("filter@%0d", c), 32'(Filter), 32'(ef));
      chk($sformatf("image@%0d", c),  32'(Image),  32'(ei));
      chk($sformatf("readen@%0d", c), 32'(ReadEn), 32'(c >= 29 && c <= 32));
      chk($sformatf("busy@%0d", c),   32'(busy),   32'(c >= 1 && c <= 33));
      chk($sformatf("done@%0d", c),   32'(done),   32'(c == 34));
      if (c == abort_at) begin
        #1 rst_n = 1'b0;
        #1;
        chk("abort_start",  32'(Start),  32'h0);
        chk("abort_readen", 32'(ReadEn), 32'h0);
        chk("abort_busy",   32'(busy),   32'h0);
        chk("abort_cksum",  32'(cksum),  32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
          @(negedge clk);
          chk("abort_nodone", 32'(done), 32'h0);
          chk("abort_idle",   32'(busy), 32'h0);
        end
        return;
      end
      go = disturb && (c == 4 || c == 19);
      if (disturb && c == 7) begin
        ld_we   = 1'b1;
        ld_sel  = 1'b0;
        ld_addr = 4'd0;
        ld_data = 4'd9;
      end else begin
        ld_we = 1'b0;
      end
    end
    go    = 1'b0;
    ld_we = 1'b0;
  endtask

  initial begin
    filt_vals = '{4'h8, 4'hF, 4'h0, 4'h1, 4'h7, 4'h3, 4'hD, 4'h2, 4'hE};
    for (int p = 0; p < 16; p++) img_vals[p] = 4'(p);
    Result  = '0;
    rst_n   = 1'b0;
    ld_we   = 1'b0;
    ld_sel  = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    go      = 1'b0;
    rd_addr = '0;
    #12;
    chk("rst_busy",    32'(busy),    32'h0);
    chk("rst_done",    32'(done),    32'h0);
    chk("rst_start",   32'(Start),   32'h0);
    chk("rst_readen",  32'(ReadEn),  32'h0);
    chk("rst_image",   32'(Image),   32'h0);
    chk("rst_filter",  32'(Filter),  32'h0);
    chk("rst_rd_data", 32'(rd_data), 32'h0);
    chk("rst_cksum",   32'(cksum),   32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 9; k++) ld(1'b1, k, filt_vals[k]);
    ld(1'b1, 9, 4'h5);
    for (int p = 0; p < 15; p++) ld(1'b0, p, img_vals[p]);

    // Frame 1: last pixel written in the same cycle as go.
    ld_we   = 1'b1;
    ld_sel  = 1'b0;
    ld_addr = 4'd15;
    ld_data = img_vals[15];
    push_stream();
    set_layer(100, -200, 511, -512);
    run_frame(0, 1'b0);
    check_results();
`ifdef FEEDER_CKSUM_EN
    chk("cksum_f1", 32'(cksum), 32'h3F9B);
`else
    chk("cksum_f1", 32'(cksum), 32'h0);
`endif

    // Frame 2: go pulses and an image write while busy are ignored.
    push_stream();
    set_layer(1, 2, 3, -4);
    run_frame(0, 1'b1);
    check_results();
`ifdef FEEDER_CKSUM_EN
    chk("cksum_f2", 32'(cksum), 32'h0002);
`else
    chk("cksum_f2", 32'(cksum), 32'h0);
`endif

    // Frame 3: reset in the middle of the pixel stream.
    push_stream();
    run_frame(15, 1'b0);
    exp_filt.delete();
    exp_img.delete();

    // Frame 4: full frame after the aborted one, buffers retained.
    push_stream();
    set_layer(7, -1, 0, 300);
    run_frame(0, 1'b0);
    check_results();
`ifdef FEEDER_CKSUM_EN
    chk("cksum_f4", 32'(cksum), 32'h0132);
`else
    chk("cksum_f4", 32'(cksum), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
